mfp_io_debounce: RTL and testbench

- Input-conditioning stage directly upstream of the AHB GPIO block.
- Synchronises raw board switches and pushbuttons into HCLK and filters contact bounce per bit.
- Delivers clean, stable levels to the GPIO read path (IO_Switch / IO_PB).
- Optionally produces single-cycle press/release event pulses for the pushbuttons.

---
 rtl/mfp_io_debounce.sv | 129 ++++++++++++
 tb/tb_mfp_io_debounce.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_io_debounce.sv
// Switch/pushbutton conditioner: per-bit synchroniser plus debounce filter in HCLK.
// Define MFP_DB_EDGE_EN to build the registered pb_press / pb_release pulse outputs.
module mfp_io_debounce #(
    parameter int N_SW        = 16,
    parameter int N_PB        = 6,
    parameter int DB_CYCLES   = 250000,
    parameter int SYNC_STAGES = 2
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic [N_SW-1:0] sw_raw,
    input  logic [N_PB-1:0] pb_raw,
    output logic [N_SW-1:0] sw_db,
    output logic [N_PB-1:0] pb_db,
    output logic [N_PB-1:0] pb_press,
    output logic [N_PB-1:0] pb_release
);

    localparam int N  = N_SW + N_PB;
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } db_state_e;

    logic [N-1:0]                  raw_all;
    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0]                  sync_bits;
    logic [N-1:0]                  db_all;

    assign raw_all   = {pb_raw, sw_raw};
    assign sync_bits = sync_q[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_all};
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_filter
        db_state_e     state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          db_q, db_d;

        // cnt_q holds how many consecutive mismatching samples have been taken;
        // db flips on the DB_CYCLES-th one, so a DB_CYCLES-cycle pulse just passes.
        always_comb begin
            // NOTE: defaults first so every path assigns every output and no latch is inferred.
            state_d = state_q;
            cnt_d   = cnt_q;
            db_d    = db_q;
            case (state_q)
                ST_STABLE: begin
                    if (sync_bits[i] != db_q) begin
                        if (DB_CYCLES == 1) begin
                            db_d = sync_bits[i];
                        end else begin
                            state_d = ST_COUNTING;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                ST_COUNTING: begin
                    if (sync_bits[i] == db_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                        db_d    = sync_bits[i];
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                state_q <= ST_STABLE;
                cnt_q   <= '0;
                db_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                db_q    <= db_d;
            end
        end

        assign db_all[i] = db_q;
    end

    assign sw_db = db_all[N_SW-1:0];
    assign pb_db = db_all[N-1:N_SW];

`ifdef MFP_DB_EDGE_EN
    logic [N_PB-1:0] pb_prev_q;
    logic [N_PB-1:0] press_q;
    logic [N_PB-1:0] release_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pb_prev_q <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            pb_prev_q <= pb_db;
            press_q   <= pb_db & ~pb_prev_q;
            release_q <= ~pb_db & pb_prev_q;
        end
    end

    assign pb_press   = press_q;
    assign pb_release = release_q;
`else
    assign pb_press   = '0;
    assign pb_release = '0;
`endif

endmodule

// File: tb/tb_mfp_io_debounce.sv
// Self-checking bench for mfp_io_debounce with DB_CYCLES=8, SYNC_STAGES=2.
// Directed scenarios use fixed expectations; the random run uses a sliding-window reference model.
module tb_mfp_io_debounce;

    localparam int N_SW = 16;
    localparam int N_PB = 6;
    localparam int DB   = 8;
    localparam int SS   = 2;
    localparam int N    = N_SW + N_PB;
    localparam int HL   = SS + DB;
`ifdef MFP_DB_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic            HCLK = 1'b0;
    logic            HRESETn;
    logic [N_SW-1:0] sw_raw;
    logic [N_PB-1:0] pb_raw;
    logic [N_SW-1:0] sw_db;
    logic [N_PB-1:0] pb_db;
    logic [N_PB-1:0] pb_press;
    logic [N_PB-1:0] pb_release;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    mfp_io_debounce #(
        .N_SW(N_SW), .N_PB(N_PB), .DB_CYCLES(DB), .SYNC_STAGES(SS)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .sw_raw(sw_raw), .pb_raw(pb_raw),
        .sw_db(sw_db), .pb_db(pb_db), .pb_press(pb_press), .pb_release(pb_release)
    );

    always #5 HCLK = ~HCLK;

    // Reference model: h[k] is the raw word sampled k edges ago. The filter sees raw
    // delayed by SS edges, and db takes value v once the DB most recent filtered
    // samples all equal v while v differs from the current db.
    logic [N-1:0] h [HL];
    logic [N-1:0] m_db, m_db_d1, m_press, m_rel;

    function automatic void model_reset();
        for (int k = 0; k < HL; k++) h[k] = '0;
        m_db = '0; m_db_d1 = '0; m_press = '0; m_rel = '0;
    endfunction

    function automatic void model_edge();
        logic v;
        logic same;
        if (!HRESETn) begin
            model_reset();
            return;
        end
        for (int k = HL - 1; k > 0; k--) h[k] = h[k-1];
        h[0]    = {pb_raw, sw_raw};
        m_press = m_db & ~m_db_d1;
        m_rel   = ~m_db & m_db_d1;
        m_db_d1 = m_db;
        for (int b = 0; b < N; b++) begin
            v    = h[SS][b];
            same = 1'b1;
            for (int k = SS; k < HL; k++) if (h[k][b] != v) same = 1'b0;
            if (same && v != m_db[b]) m_db[b] = v;
        end
    endfunction

    task automatic tick();
        @(posedge HCLK);
        model_edge();
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        sw_raw  = '1;
        pb_raw  = '0;
        model_reset();
        repeat (3) tick();
        n_vec++;
        if ({sw_db, pb_db, pb_press, pb_release} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got sw=%h pb=%h press=%b rel=%b, want all 0", sw_db, pb_db, pb_press, pb_release);
        end
        HRESETn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_vec++;
            if (sw_db !== ((k >= 10) ? 16'hFFFF : 16'h0000)) begin
                n_err++;
                $display("FAIL powerup_sw edge %0d: got %h want %h", k, sw_db, (k >= 10) ? 16'hFFFF : 16'h0000);
            end
            n_vec++;
            if ({pb_db, pb_press, pb_release} !== '0) begin
                n_err++;
                $display("FAIL powerup_pb edge %0d: got pb=%b press=%b rel=%b want 0", k, pb_db, pb_press, pb_release);
            end
        end
    endtask

    task automatic test_pb_step();
        logic [N_PB-1:0] exp_db, exp_pr;
        pb_raw = 6'b000001;
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp_db = (k >= 10) ? 6'b000001 : 6'b000000;
            exp_pr = (EDGE_EN && k == 11) ? 6'b000001 : 6'b000000;
            n_vec++;
            if (pb_db !== exp_db || pb_press !== exp_pr || pb_release !== '0 || sw_db !== 16'hFFFF) begin
                n_err++;
                $display("FAIL pb_step edge %0d: got db=%b press=%b rel=%b sw=%h want db=%b press=%b rel=0 sw=ffff",
                         k, pb_db, pb_press, pb_release, sw_db, exp_db, exp_pr);
            end
        end
    endtask

    task automatic test_pb_bounce();
        for (int k = 0; k < 40; k++) begin
            pb_raw[2] = (k < 5) || (k >= 8 && k < 13);
            tick();
            n_vec++;
            if (pb_db !== 6'b000001 || pb_press !== '0 || pb_release !== '0) begin
                n_err++;
                $display("FAIL pb_bounce cycle %0d: got db=%b press=%b rel=%b want db=000001 press=0 rel=0",
                         k, pb_db, pb_press, pb_release);
            end
        end
    endtask

    task automatic test_pulse_width();
        logic exp_b;
        sw_raw = '0;
        repeat (20) tick();
        n_vec++;
        if (sw_db !== 16'h0000) begin
            n_err++;
            $display("FAIL sw_settle: got %h want 0000", sw_db);
        end
        for (int k = 1; k <= 20; k++) begin
            sw_raw[3] = (k <= 7);
            tick();
            n_vec++;
            if (sw_db[3] !== 1'b0) begin
                n_err++;
                $display("FAIL width7 edge %0d: got %b want 0", k, sw_db[3]);
            end
        end
        for (int k = 1; k <= 24; k++) begin
            sw_raw[3] = (k <= 8);
            tick();
            exp_b = (k >= 10 && k < 18);
            n_vec++;
            if (sw_db[3] !== exp_b) begin
                n_err++;
                $display("FAIL width8 edge %0d: got %b want %b", k, sw_db[3], exp_b);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [N_PB-1:0] exp_pr;
        sw_raw = 16'h0020;
        repeat (8) tick();
        HRESETn = 1'b0;
        #1;
        n_vec++;
        if ({sw_db, pb_db, pb_press, pb_release} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got sw=%h pb=%b press=%b rel=%b want all 0", sw_db, pb_db, pb_press, pb_release);
        end
        repeat (2) tick();
        HRESETn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_pr = (EDGE_EN && k == 11) ? 6'b000001 : 6'b000000;
            n_vec++;
            if (sw_db !== ((k >= 10) ? 16'h0020 : 16'h0000) || pb_db !== ((k >= 10) ? 6'b000001 : 6'b000000)
                || pb_press !== exp_pr) begin
                n_err++;
                $display("FAIL reset_restart edge %0d: got sw=%h pb=%b press=%b want sw=%h pb=%b press=%b",
                         k, sw_db, pb_db, pb_press, (k >= 10) ? 16'h0020 : 16'h0000,
                         (k >= 10) ? 6'b000001 : 6'b000000, exp_pr);
            end
        end
    endtask

    task automatic test_all_buttons();
        logic [N_PB-1:0] exp_db, exp_pr, exp_rl;
        pb_raw = 6'b111111;
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp_db = (k >= 10) ? 6'b111111 : 6'b000001;
            exp_pr = (EDGE_EN && k == 11) ? 6'b111110 : 6'b000000;
            n_vec++;
            if (pb_db !== exp_db || pb_press !== exp_pr || pb_release !== '0) begin
                n_err++;
                $display("FAIL all_press edge %0d: got db=%b press=%b rel=%b want db=%b press=%b rel=0",
                         k, pb_db, pb_press, pb_release, exp_db, exp_pr);
            end
        end
        pb_raw = 6'b000000;
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp_db = (k >= 10) ? 6'b000000 : 6'b111111;
            exp_rl = (EDGE_EN && k == 11) ? 6'b111111 : 6'b000000;
            n_vec++;
            if (pb_db !== exp_db || pb_release !== exp_rl || pb_press !== '0) begin
                n_err++;
                $display("FAIL all_release edge %0d: got db=%b press=%b rel=%b want db=%b press=0 rel=%b",
                         k, pb_db, pb_press, pb_release, exp_db, exp_rl);
            end
        end
    endtask

    task automatic test_random();
        logic [N_PB-1:0] exp_pr, exp_rl;
        for (int k = 0; k < 2000; k++) begin
            for (int b = 0; b < N_SW; b++) if ($urandom_range(5) == 0) sw_raw[b] = ~sw_raw[b];
            for (int b = 0; b < N_PB; b++) if ($urandom_range(5) == 0) pb_raw[b] = ~pb_raw[b];
            if ($urandom_range(99) == 0) begin
                sw_raw = 16'($urandom);
                pb_raw = 6'($urandom);
                repeat (12) tick();
            end
            tick();
            exp_pr = EDGE_EN ? m_press[N-1:N_SW] : '0;
            exp_rl = EDGE_EN ? m_rel[N-1:N_SW] : '0;
            n_vec++;
            if (sw_db !== m_db[N_SW-1:0] || pb_db !== m_db[N-1:N_SW]) begin
                n_err++;
                $display("FAIL rand_db cycle %0d: got sw=%h pb=%b want sw=%h pb=%b",
                         cyc, sw_db, pb_db, m_db[N_SW-1:0], m_db[N-1:N_SW]);
            end
            n_vec++;
            if (pb_press !== exp_pr || pb_release !== exp_rl) begin
                n_err++;
                $display("FAIL rand_edge cycle %0d: got press=%b rel=%b want press=%b rel=%b",
                         cyc, pb_press, pb_release, exp_pr, exp_rl);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0;
        sw_raw  = '0;
        pb_raw  = '0;
        #2;
        test_reset();
        test_pb_step();
        test_pb_bounce();
        test_pulse_width();
        test_reset_mid_count();
        test_all_buttons();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
